// File: rtl/chip_test_harness_pkg.sv
// Shared constants for the chip test harness: TSI commands, word address map,
// TSI state encoding and mailbox failure codes.
package chip_test_harness_pkg;

   localparam logic [31:0] CMD_READ  = 32'd0;
   localparam logic [31:0] CMD_WRITE = 32'd1;

   localparam logic [31:0] ADDR_TOHOST      = 32'h0000_0400;
   localparam logic [31:0] ADDR_FROMHOST    = 32'h0000_0401;
   localparam logic [31:0] ADDR_ADC_MIN     = 32'h0000_0402;
   localparam logic [31:0] ADDR_ADC_MAX     = 32'h0000_0403;
   localparam logic [31:0] ADDR_ADC_COUNT   = 32'h0000_0404;
   localparam logic [31:0] ADDR_CYCLE_COUNT = 32'h0000_0405;

   localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

   localparam logic [30:0] FAIL_BAD_TOHOST = 31'h7FFF_FFFF;
   localparam logic [30:0] FAIL_TIMEOUT    = 31'h7FFF_FFFE;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StLen,
      StWdata,
      StRdata
   } tsi_state_e;

   // Failure code for a locked, non-success tohost value.
   function automatic logic [30:0] tohost_fail_code(input logic [31:0] value);
      return value[0] ? value[31:1] : FAIL_BAD_TOHOST;
   endfunction

endpackage

// File: rtl/chip_test_harness_if.sv
// TSI word-stream interface: host-to-harness command/data words and
// harness-to-host read-data words, each with a valid/ready handshake.
interface chip_test_harness_if;

   logic        io_tsi_in_valid;
   logic        io_tsi_in_ready;
   logic [31:0] io_tsi_in_bits;
   logic        io_tsi_out_valid;
   logic        io_tsi_out_ready;
   logic [31:0] io_tsi_out_bits;

   modport master (
      output io_tsi_in_valid,
      output io_tsi_in_bits,
      output io_tsi_out_ready,
      input  io_tsi_in_ready,
      input  io_tsi_out_valid,
      input  io_tsi_out_bits
   );

   modport slave (
      input  io_tsi_in_valid,
      input  io_tsi_in_bits,
      input  io_tsi_out_ready,
      output io_tsi_in_ready,
      output io_tsi_out_valid,
      output io_tsi_out_bits
   );

endinterface

// File: rtl/chip_test_harness_adc_mon.sv
// ADC sample statistics: running min, max and sample count, with a clear that
// takes priority over a coincident sample.
module chip_test_harness_adc_mon #(
   parameter int unsigned ADC_W = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [ADC_W-1:0] sample,
   input  logic             clear,
   output logic [31:0]      adc_min,
   output logic [31:0]      adc_max,
   output logic [31:0]      adc_count
);

   logic [ADC_W-1:0] min_q;
   logic [ADC_W-1:0] max_q;
   logic [31:0]      count_q;

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         min_q   <= '1;
         max_q   <= '0;
         count_q <= '0;
      end else if (sample_valid) begin
         count_q <= count_q + 32'd1;
         if (sample < min_q) min_q <= sample;
         if (sample > max_q) max_q <= sample;
      end
   end

   assign adc_min   = 32'(min_q);
   assign adc_max   = 32'(max_q);
   assign adc_count = count_q;

endmodule

// File: rtl/chip_test_harness.sv
// Chip test harness top: TSI word-stream target, scratch RAM, tohost/fromhost
// mailbox and ADC monitor. Define HARNESS_TIMEOUT_EN to enable the cycle timeout.
module chip_test_harness
   import chip_test_harness_pkg::*;
#(
   parameter int unsigned MEM_WORDS      = 64,
   parameter int unsigned ADC_W          = 9,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                      clock,
   input  logic                      reset,
   chip_test_harness_if.slave        tsi,
   input  logic                      io_adc_valid,
   input  logic [ADC_W-1:0]          io_adc_sample,
   output logic                      io_success,
   output logic                      io_failure,
   output logic [30:0]               io_fail_code
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

`ifdef HARNESS_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   tsi_state_e  state_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic        is_write_q;
   logic [31:0] addr_q;
   logic [31:0] count_q;
   logic [31:0] tohost_q;
   logic [31:0] fromhost_q;
   logic [31:0] cycle_q;
   logic        success_q;
   logic        failure_q;
   logic [30:0] fail_code_q;
   logic [31:0] mem_q [MEM_WORDS];

   logic [31:0] in_bits;
   logic        in_fire;
   logic        out_fire;
   logic        wr_fire;
   logic        last_word;
   logic        addr_in_ram;
   logic        adc_clear;
   logic        tohost_take;
   logic        timeout_hit;
   logic [31:0] rd_data;
   logic [31:0] adc_min;
   logic [31:0] adc_max;
   logic [31:0] adc_count;

   assign in_bits     = tsi.io_tsi_in_bits;
   assign in_fire     = tsi.io_tsi_in_valid && in_ready_q;
   assign out_fire    = out_valid_q && tsi.io_tsi_out_ready;
   assign wr_fire     = reset && in_fire && (state_q == StWdata);
   // count_q holds the number of words left minus one, so zero marks the last word
   assign last_word   = (count_q == 32'd0);
   assign addr_in_ram = (addr_q < 32'(MEM_WORDS));
   assign adc_clear   = wr_fire && (addr_q == ADDR_ADC_COUNT);
   assign tohost_take = wr_fire && (addr_q == ADDR_TOHOST) && (tohost_q == 32'd0);
   assign timeout_hit = TimeoutEn && (cycle_q == 32'(TIMEOUT_CYCLES));

   chip_test_harness_adc_mon #(
      .ADC_W (ADC_W)
   ) u_adc_mon (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (io_adc_valid),
      .sample       (io_adc_sample),
      .clear        (adc_clear),
      .adc_min      (adc_min),
      .adc_max      (adc_max),
      .adc_count    (adc_count)
   );

   always_comb begin
      rd_data = UNMAPPED_DATA;
      if (addr_in_ram) begin
         rd_data = mem_q[addr_q[AW-1:0]];
      end else begin
         case (addr_q)
            ADDR_TOHOST:      rd_data = tohost_q;
            ADDR_FROMHOST:    rd_data = fromhost_q;
            ADDR_ADC_MIN:     rd_data = adc_min;
            ADDR_ADC_MAX:     rd_data = adc_max;
            ADDR_ADC_COUNT:   rd_data = adc_count;
            ADDR_CYCLE_COUNT: rd_data = cycle_q;
            default:          rd_data = UNMAPPED_DATA;
         endcase
      end
   end

   // Scratch RAM has no reset so words written before a reset survive it.
   always_ff @(posedge clock) begin
      if (wr_fire && addr_in_ram) mem_q[addr_q[AW-1:0]] <= in_bits;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         count_q     <= '0;
         tohost_q    <= '0;
         fromhost_q  <= '0;
         cycle_q     <= '0;
         success_q   <= 1'b0;
         failure_q   <= 1'b0;
         fail_code_q <= '0;
      end else begin
         cycle_q    <= cycle_q + 32'd1;
         in_ready_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               if (in_fire && (in_bits == CMD_READ || in_bits == CMD_WRITE)) begin
                  is_write_q <= (in_bits == CMD_WRITE);
                  state_q    <= StAddr;
               end
            end
            StAddr: begin
               if (in_fire) begin
                  addr_q  <= in_bits;
                  state_q <= StLen;
               end
            end
            StLen: begin
               if (in_fire) begin
                  count_q <= in_bits;
                  if (is_write_q) begin
                     state_q <= StWdata;
                  end else begin
                     state_q     <= StRdata;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            StWdata: begin
               if (in_fire) begin
                  addr_q  <= addr_q + 32'd1;
                  count_q <= count_q - 32'd1;
                  if (last_word) state_q <= StIdle;
               end
            end
            StRdata: begin
               in_ready_q <= 1'b0;
               if (out_fire) begin
                  addr_q  <= addr_q + 32'd1;
                  count_q <= count_q - 32'd1;
                  if (last_word) begin
                     state_q     <= StIdle;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
            end
         endcase

         if (wr_fire && addr_q == ADDR_FROMHOST) fromhost_q <= in_bits;
         if (tohost_take) tohost_q <= in_bits;

         // Status is decided once; a tohost lock beats a timeout in the same cycle.
         if (!success_q && !failure_q) begin
            if (tohost_take && in_bits != 32'd0) begin
               if (in_bits == 32'd1) begin
                  success_q <= 1'b1;
               end else begin
                  failure_q   <= 1'b1;
                  fail_code_q <= tohost_fail_code(in_bits);
               end
            end else if (timeout_hit) begin
               failure_q   <= 1'b1;
               fail_code_q <= FAIL_TIMEOUT;
            end
         end
      end
   end

   assign tsi.io_tsi_in_ready  = in_ready_q;
   assign tsi.io_tsi_out_valid = out_valid_q;
   assign tsi.io_tsi_out_bits  = out_valid_q ? rd_data : 32'd0;
   assign io_success           = success_q;
   assign io_failure           = failure_q;
   assign io_fail_code         = fail_code_q;

endmodule

// File: tb/tb_chip_test_harness.sv
// Self-checking bench for chip_test_harness: vector table, directed corner
// sequences and randomized bursts/samples against a behavioural memory-map model.
module tb_chip_test_harness;

   localparam int unsigned MEM_WORDS = 64;
   localparam int unsigned ADC_W     = 9;
`ifdef HARNESS_TIMEOUT_EN
   localparam int unsigned TIMEOUT = 50;
`else
   localparam int unsigned TIMEOUT = 1000000;
`endif

   logic             clock;
   logic             reset;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_sample;
   logic             success;
   logic             failure;
   logic [30:0]      fail_code;

   chip_test_harness_if tsi ();

   chip_test_harness #(
      .MEM_WORDS      (MEM_WORDS),
      .ADC_W          (ADC_W),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .tsi           (tsi),
      .io_adc_valid  (adc_valid),
      .io_adc_sample (adc_sample),
      .io_success    (success),
      .io_failure    (failure),
      .io_fail_code  (fail_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Bench cycle counter: edges seen since reset was last released.
   logic [31:0] cyc;
   always @(posedge clock) begin
      if (!reset) cyc <= 32'd0;
      else        cyc <= cyc + 32'd1;
   end

   // Reference model of the word address map.
   logic [31:0] ram_m [MEM_WORDS];
   logic [31:0] tohost_m;
   logic [31:0] fromhost_m;
   int unsigned adc_min_m;
   int unsigned adc_max_m;
   int unsigned adc_cnt_m;
   logic [31:0] wq [$];

   function automatic void model_reset();
      tohost_m   = 32'd0;
      fromhost_m = 32'd0;
      adc_min_m  = (1 << ADC_W) - 1;
      adc_max_m  = 0;
      adc_cnt_m  = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a < 32'(MEM_WORDS)) return ram_m[a[5:0]];
      case (a)
         32'h400: return tohost_m;
         32'h401: return fromhost_m;
         32'h402: return adc_min_m;
         32'h403: return adc_max_m;
         32'h404: return adc_cnt_m;
         32'h405: return cyc;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
      if (a < 32'(MEM_WORDS)) ram_m[a[5:0]] = d;
      else if (a == 32'h400 && tohost_m == 32'd0) tohost_m = d;
      else if (a == 32'h401) fromhost_m = d;
      else if (a == 32'h404) begin
         adc_min_m = (1 << ADC_W) - 1;
         adc_max_m = 0;
         adc_cnt_m = 0;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at #1 after a clock edge; returns at #1 after the handshake edge.
   task automatic send_word(input logic [31:0] w, input bit with_sample = 1'b0,
                            input logic [ADC_W-1:0] s = '0);
      int guard = 0;
      tsi.io_tsi_in_valid = 1'b1;
      tsi.io_tsi_in_bits  = w;
      while (tsi.io_tsi_in_ready !== 1'b1 && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      if (guard >= 100) begin
         n_checks++;
         n_errors++;
         $display("FAIL in_ready_wait: got 0, expected 1 within 100 cycles");
      end
      if (with_sample) begin
         adc_valid  = 1'b1;
         adc_sample = s;
      end
      @(posedge clock); #1;
      tsi.io_tsi_in_valid = 1'b0;
      adc_valid           = 1'b0;
   endtask

   task automatic write_burst(input logic [31:0] addr);
      send_word(32'd1);
      send_word(addr);
      send_word(32'(wq.size() - 1));
      foreach (wq[i]) begin
         send_word(wq[i]);
         model_write(addr + 32'(i), wq[i]);
      end
   endtask

   task automatic write_one(input logic [31:0] addr, input logic [31:0] d);
      wq = {d};
      write_burst(addr);
   endtask

   task automatic read_burst(input string name, input logic [31:0] addr, input int n,
                             input bit toggle);
      int got = 0;
      int cycles = 0;
      send_word(32'd0);
      send_word(addr);
      send_word(32'(n - 1));
      tsi.io_tsi_out_ready = !toggle;
      while (got < n && cycles < 100) begin
         check({name, " valid"}, 32'(tsi.io_tsi_out_valid), 32'd1);
         check({name, " data"}, tsi.io_tsi_out_bits, model_read(addr + 32'(got)));
         if (tsi.io_tsi_out_valid && tsi.io_tsi_out_ready) got++;
         @(posedge clock); #1;
         cycles++;
         if (toggle) tsi.io_tsi_out_ready = ~tsi.io_tsi_out_ready;
      end
      tsi.io_tsi_out_ready = 1'b0;
      check({name, " cycles"}, 32'(cycles), toggle ? 32'(2 * n) : 32'(n));
      check({name, " end_valid"}, 32'(tsi.io_tsi_out_valid), 32'd0);
   endtask

   task automatic adc_drive(input int unsigned s);
      adc_valid  = 1'b1;
      adc_sample = s[ADC_W-1:0];
      @(posedge clock); #1;
      adc_valid  = 1'b0;
      adc_cnt_m++;
      if (s < adc_min_m) adc_min_m = s;
      if (s > adc_max_m) adc_max_m = s;
   endtask

   task automatic check_status(input string name, input bit s, input bit f,
                               input logic [30:0] code);
      check({name, " success"}, 32'(success), 32'(s));
      check({name, " failure"}, 32'(failure), 32'(f));
      check({name, " fail_code"}, 32'(fail_code), 32'(code));
   endtask

   task automatic do_reset();
      reset                = 1'b0;
      tsi.io_tsi_in_valid  = 1'b0;
      tsi.io_tsi_out_ready = 1'b0;
      adc_valid            = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      check("rst in_ready", 32'(tsi.io_tsi_in_ready), 32'd0);
      check("rst out_valid", 32'(tsi.io_tsi_out_valid), 32'd0);
      check_status("rst", 1'b0, 1'b0, 31'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      check("post_rst in_ready", 32'(tsi.io_tsi_in_ready), 32'd1);
      model_reset();
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      bit          do_write;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{"ram5",      32'h5,        1'b1, 32'h12345678, 32'h12345678};
      vecs[1] = '{"ram_top",   32'h3F,       1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[2] = '{"ram_past",  32'h40,       1'b1, 32'h11111111, 32'hDEADBEEF};
      vecs[3] = '{"unmap7ff",  32'h7FF,      1'b0, 32'h0,        32'hDEADBEEF};
      vecs[4] = '{"unmap_max", 32'hFFFFFFFF, 1'b0, 32'h0,        32'hDEADBEEF};
      vecs[5] = '{"fromhost",  32'h401,      1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[6] = '{"adc_min_ro", 32'h402,     1'b1, 32'h55,       32'h1FF};
      vecs[7] = '{"adc_max_ro", 32'h403,     1'b1, 32'h77,       32'h0};
      vecs[8] = '{"adc_cnt",   32'h404,      1'b0, 32'h0,        32'h0};
      vecs[9] = '{"tohost0",   32'h400,      1'b0, 32'h0,        32'h0};

      reset                = 1'b0;
      tsi.io_tsi_in_valid  = 1'b0;
      tsi.io_tsi_in_bits   = 32'd0;
      tsi.io_tsi_out_ready = 1'b0;
      adc_valid            = 1'b0;
      adc_sample           = '0;
      foreach (ram_m[i]) ram_m[i] = 32'd0;
      @(posedge clock); #1;
      do_reset();

      // Junk words in IDLE are swallowed; then the vector table.
      send_word(32'h55);
      send_word(32'h2);
      foreach (vecs[i]) begin
         if (vecs[i].do_write) write_one(vecs[i].addr, vecs[i].wdata);
         read_burst(vecs[i].name, vecs[i].addr, 1, 1'b0);
         check({vecs[i].name, " table"}, model_read(vecs[i].addr), vecs[i].exp);
      end

      wq = {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
      write_burst(32'h0);
      read_burst("burst4", 32'h0, 4, 1'b0);
      read_burst("backpressure", 32'h1, 2, 1'b1);
      read_burst("deadbeef", 32'h7FF, 1, 1'b0);

      // Randomized bursts against the model, after filling all of RAM.
      wq = {};
      for (int i = 0; i < MEM_WORDS; i++) wq.push_back($urandom);
      write_burst(32'h0);
      for (int it = 0; it < 20; it++) begin
         int unsigned a = $urandom_range(0, 70);
         int unsigned n = $urandom_range(1, 8);
         wq = {};
         for (int k = 0; k < int'(n); k++) wq.push_back($urandom);
         write_burst(32'(a));
         read_burst("rand_rd", 32'($urandom_range(0, 70)), int'($urandom_range(1, 8)),
                    1'($urandom_range(0, 1)));
      end
      read_burst("cycle_count", 32'h405, 1, 1'b0);

      // ADC statistics, clear, and clear-beats-sample.
      write_one(32'h404, 32'h0);
      adc_drive(100);
      adc_drive(3);
      adc_drive(511);
      adc_drive(250);
      check("adc_model_min", model_read(32'h402), 32'd3);
      read_burst("adc_stats", 32'h402, 3, 1'b0);
      write_one(32'h404, 32'h1234);
      read_burst("adc_cleared", 32'h402, 3, 1'b0);
      adc_drive(42);
      send_word(32'd1);
      send_word(32'h404);
      send_word(32'd0);
      send_word(32'h0, 1'b1, 9'd5);
      model_write(32'h404, 32'h0);
      read_burst("adc_clear_wins", 32'h402, 3, 1'b0);
      for (int it = 0; it < 30; it++) begin
         adc_drive($urandom_range(0, 511));
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      read_burst("adc_rand", 32'h402, 3, 1'b0);

      // Mailbox outcomes, each from a fresh reset.
      do_reset();
      write_one(32'h400, 32'd1);
      check_status("tohost1", 1'b1, 1'b0, 31'd0);
      write_one(32'h400, 32'd5);
      check_status("tohost_locked", 1'b1, 1'b0, 31'd0);
      read_burst("tohost_rd", 32'h400, 1, 1'b0);

      do_reset();
      write_one(32'h400, 32'd0);
      check_status("tohost_zero", 1'b0, 1'b0, 31'd0);
      write_one(32'h400, 32'd7);
      check_status("tohost7", 1'b0, 1'b1, 31'd3);

      do_reset();
      write_one(32'h400, 32'd4);
      check_status("tohost_even", 1'b0, 1'b1, 31'h7FFFFFFF);

      // Reset in the middle of a write burst keeps the words already written.
      do_reset();
      send_word(32'd1);
      send_word(32'd10);
      send_word(32'd3);
      send_word(32'h0BAD0010);
      send_word(32'h0BAD0011);
      model_write(32'd10, 32'h0BAD0010);
      model_write(32'd11, 32'h0BAD0011);
      do_reset();
      write_one(32'd20, 32'h600D0020);
      read_burst("mid_reset", 32'd10, 3, 1'b0);
      read_burst("after_reset", 32'd20, 1, 1'b0);

      do_reset();
      repeat (60) begin @(posedge clock); #1; end
`ifdef HARNESS_TIMEOUT_EN
      check_status("timeout", 1'b0, 1'b1, 31'h7FFFFFFE);
`else
      check_status("no_timeout", 1'b0, 1'b0, 31'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

endmodule
